data_bus_bridge: RTL and testbench

Bridges the core's single-cycle data-memory port to a request/acknowledge memory bus with arbitrary wait states. It sits directly downstream of the core's memory stage, between the core and data memory. It freezes the whole core through the core's clock-enable input until each access completes, and returns read data registered so the writeback stage sees it on the cycle after the core advances.

---
 rtl/data_bus_bridge.sv | 106 ++++++++++
 tb/tb_data_bus_bridge.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_bus_bridge.sv
// Bridges the core's single-cycle data port to a req/ack memory bus.
// Freezes the core via core_clk_en per access. The m_* outputs and read data are registered.
// Optional DBB_TIMEOUT_EN forces completion with bus_err after TIMEOUT_CYCLES.
module data_bus_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        async_rst_n,
    input  logic        clk_en_in,
    output logic        core_clk_en,
    input  logic        core_bus_lock,
    input  logic        core_memory_mode,
    input  logic [29:0] core_data_address,
    input  logic [3:0]  core_data_mask,
    input  logic [31:0] core_data_out,
    output logic [31:0] core_data_in,
    output logic        m_req,
    output logic        m_we,
    output logic [29:0] m_addr,
    output logic [3:0]  m_be,
    output logic [31:0] m_wdata,
    input  logic        m_ack,
    input  logic [31:0] m_rdata,
    output logic        bus_err
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state;
    logic [31:0] rdata_q;
    logic        tmo_hit;

`ifdef DBB_TIMEOUT_EN
    logic [15:0] tmo_cnt;

    // tmo_cnt counts REQ cycles already elapsed, so the hit lands in the last allowed cycle
    assign tmo_hit = (state == REQ) && (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            tmo_cnt <= 16'd0;
            bus_err <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            if (state == REQ) begin
                tmo_cnt <= tmo_cnt + 16'd1;
                if (tmo_hit && !m_ack)
                    bus_err <= 1'b1;
            end else begin
                tmo_cnt <= 16'd0;
            end
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state   <= IDLE;
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= 30'd0;
            m_be    <= 4'd0;
            m_wdata <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (core_bus_lock && clk_en_in) begin
                        m_req   <= 1'b1;
                        m_we    <= core_memory_mode;
                        m_addr  <= core_data_address;
                        m_be    <= core_data_mask;
                        m_wdata <= core_data_out;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    // An ack arriving with the timeout takes priority over the error path
                    if (m_ack) begin
                        if (!m_we)
                            rdata_q <= m_rdata;
                        m_req <= 1'b0;
                        state <= DONE;
                    end else if (tmo_hit) begin
                        if (!m_we)
                            rdata_q <= 32'hFFFF_FFFF;
                        m_req <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (clk_en_in)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign core_clk_en  = clk_en_in && !(core_bus_lock && (state != DONE));
    assign core_data_in = rdata_q;

endmodule

// File: tb/tb_data_bus_bridge.sv
// Directed bench for data_bus_bridge: stall length, bus field stability, read data, reset, timeout.
module tb_data_bus_bridge;

    logic        clk = 1'b0;
    logic        async_rst_n;
    logic        clk_en_in;
    logic        core_clk_en;
    logic        core_bus_lock;
    logic        core_memory_mode;
    logic [29:0] core_data_address;
    logic [3:0]  core_data_mask;
    logic [31:0] core_data_out;
    logic [31:0] core_data_in;
    logic        m_req;
    logic        m_we;
    logic [29:0] m_addr;
    logic [3:0]  m_be;
    logic [31:0] m_wdata;
    logic        m_ack;
    logic [31:0] m_rdata;
    logic        bus_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rises    = 0;
    logic req_prev = 1'b0;

    data_bus_bridge #(.TIMEOUT_CYCLES(8)) dut (
        .clk               (clk),
        .async_rst_n       (async_rst_n),
        .clk_en_in         (clk_en_in),
        .core_clk_en       (core_clk_en),
        .core_bus_lock     (core_bus_lock),
        .core_memory_mode  (core_memory_mode),
        .core_data_address (core_data_address),
        .core_data_mask    (core_data_mask),
        .core_data_out     (core_data_out),
        .core_data_in      (core_data_in),
        .m_req             (m_req),
        .m_we              (m_we),
        .m_addr            (m_addr),
        .m_be              (m_be),
        .m_wdata           (m_wdata),
        .m_ack             (m_ack),
        .m_rdata           (m_rdata),
        .bus_err           (bus_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (m_req && !req_prev)
            rises = rises + 1;
        req_prev = m_req;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one access and plays the memory, acking on REQ cycle index 'waits'.
    // Returns after the edge on which the core advances, with bus_lock dropped.
    task automatic do_access(input string tag, input logic we, input logic [29:0] addr,
                             input logic [3:0] be, input logic [31:0] wdata,
                             input int waits, input logic [31:0] rdata,
                             output int stall, output int req_cycles,
                             output int req_start, output int req_end, output int errs);
        int unstable = 0;
        bit done = 0;
        stall = 0; req_cycles = 0; req_start = -1; req_end = -1; errs = 0;
        core_bus_lock     = 1'b1;
        core_memory_mode  = we;
        core_data_address = addr;
        core_data_mask    = be;
        core_data_out     = wdata;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (bus_err) errs++;
            if (m_req) begin
                if (req_start < 0) req_start = cyc;
                if (m_we !== we || m_addr !== addr || m_be !== be || m_wdata !== wdata)
                    unstable++;
                m_ack   = (req_cycles == waits);
                m_rdata = rdata;
                if (m_ack) req_end = cyc;
                req_cycles++;
            end else begin
                m_ack = 1'b0;
            end
            if (core_clk_en) done = 1;
            else stall++;
        end
        check({tag, "_completed"}, 32'(done), 32'd1);
        check({tag, "_fields_stable"}, unstable, 0);
        tick();
        core_bus_lock = 1'b0;
        m_ack = 1'b0;
    endtask

    int stall, reqc, rs1, re1, rs2, re2, errs, r0;

    initial begin
        async_rst_n = 1'b0; clk_en_in = 1'b1; core_bus_lock = 1'b0;
        core_memory_mode = 1'b0; core_data_address = '0; core_data_mask = '0;
        core_data_out = '0; m_ack = 1'b0; m_rdata = '0;
        tick(); tick();
        @(negedge clk);
        check("rst_m_req", 32'(m_req), 0);
        check("rst_clk_en", 32'(core_clk_en), 1);
        check("rst_rdata", core_data_in, 32'h0);
        check("rst_bus_err", 32'(bus_err), 0);
        check("rst_m_addr", 32'(m_addr), 0);
        async_rst_n = 1'b1;
        tick();

        // Read, ack in first REQ cycle
        do_access("rd0", 1'b0, 30'h40, 4'hF, 32'h0, 0, 32'h1234_5678, stall, reqc, rs1, re1, errs);
        check("rd0_stall", stall, 2);
        check("rd0_req_cycles", reqc, 1);
        check("rd0_no_err", errs, 0);
        @(negedge clk);
        check("rd0_data", core_data_in, 32'h1234_5678);
        check("rd0_clk_en_after", 32'(core_clk_en), 1);
        tick();

        // Write with 3 wait states
        do_access("wr3", 1'b1, 30'h10, 4'b0011, 32'hAABB_CCDD, 3, 32'h5555_5555, stall, reqc, rs1, re1, errs);
        check("wr3_stall", stall, 5);
        check("wr3_req_cycles", reqc, 4);
        @(negedge clk);
        check("wr3_rdata_kept", core_data_in, 32'h1234_5678);
        tick();

        // Back-to-back read then write, no idle gap from the core
        r0 = rises;
        do_access("b2b_rd", 1'b0, 30'h100, 4'hF, 32'h0, 1, 32'h0BAD_BEEF, stall, reqc, rs1, re1, errs);
        check("b2b_rd_stall", stall, 3);
        do_access("b2b_wr", 1'b1, 30'h104, 4'b1100, 32'h0102_0304, 0, 32'h0, stall, reqc, rs2, re2, errs);
        check("b2b_wr_stall", stall, 2);
        check("b2b_gap", rs2 - re1, 3);
        @(negedge clk);
        check("b2b_req_pulses", rises - r0, 2);
        check("b2b_rdata", core_data_in, 32'h0BAD_BEEF);
        tick();

        // clk_en_in held low for 3 cycles in DONE
        r0 = rises;
        core_bus_lock = 1'b1; core_memory_mode = 1'b0; core_data_address = 30'h20;
        core_data_mask = 4'hF;
        @(negedge clk);
        check("ce_stall_c0", 32'(core_clk_en), 0);
        @(negedge clk);
        check("ce_req_c1", 32'(m_req), 1);
        m_ack = 1'b1; m_rdata = 32'hCAFE_F00D;
        tick();
        m_ack = 1'b0; clk_en_in = 1'b0;
        begin
            int held = 0;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                if (!core_clk_en && !m_req) held++;
                if (i < 2) tick();
            end
            check("ce_held_done", held, 3);
        end
        tick();
        clk_en_in = 1'b1;
        @(negedge clk);
        check("ce_release", 32'(core_clk_en), 1);
        tick();
        core_bus_lock = 1'b0;
        @(negedge clk);
        check("ce_data", core_data_in, 32'hCAFE_F00D);
        check("ce_req_pulses", rises - r0, 1);
        tick();

        // Reset asserted while in REQ
        core_bus_lock = 1'b1; core_memory_mode = 1'b1; core_data_address = 30'h3FF;
        core_data_mask = 4'b0101; core_data_out = 32'hDEAD_0001;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_req_before", 32'(m_req), 1);
        #2;
        async_rst_n = 1'b0; core_bus_lock = 1'b0;
        #1;
        check("rst_mid_m_req", 32'(m_req), 0);
        check("rst_mid_clk_en", 32'(core_clk_en), 1);
        check("rst_mid_m_we", 32'(m_we), 0);
        check("rst_mid_m_addr", 32'(m_addr), 0);
        check("rst_mid_m_be", 32'(m_be), 0);
        check("rst_mid_m_wdata", m_wdata, 32'h0);
        check("rst_mid_rdata", core_data_in, 32'h0);
        tick();
        async_rst_n = 1'b1;
        tick();

`ifdef DBB_TIMEOUT_EN
        do_access("tmo", 1'b0, 30'h80, 4'hF, 32'h0, 1000, 32'h0, stall, reqc, rs1, re1, errs);
        check("tmo_stall", stall, 9);
        check("tmo_req_cycles", reqc, 8);
        check("tmo_err_pulses", errs, 1);
        @(negedge clk);
        check("tmo_rdata", core_data_in, 32'hFFFF_FFFF);
        check("tmo_err_cleared", 32'(bus_err), 0);
        check("tmo_resumed", 32'(core_clk_en), 1);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
